// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the DIV/DIVU sequencer.
// Holds the state encodings, default width and end-to-end latency.
package div_ctrl_pkg;

   localparam int DIV_W       = 32;
   localparam int DIV_LATENCY = DIV_W + 3;

   typedef enum logic [2:0] {
      DIV_IDLE = 3'd0,
      DIV_PREP = 3'd1,
      DIV_ITER = 3'd2,
      DIV_FIX  = 3'd3,
      DIV_DONE = 3'd4
   } div_state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider bundle: start/sign/operands/cancel in,
// stall/busy/result pulse and HI/LO out. master = EX, slave = divider.
interface div_ctrl_if
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_W
);

   logic             start_i;
   logic             signed_i;
   logic [WIDTH-1:0] opa_i;
   logic [WIDTH-1:0] opb_i;
   logic             cancel_i;
   logic             stall_o;
   logic             busy_o;
   logic             result_valid_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, signed_i, opa_i, opb_i, cancel_i,
      input  stall_o, busy_o, result_valid_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, signed_i, opa_i, opb_i, cancel_i,
      output stall_o, busy_o, result_valid_o, hi_o, lo_o
   );

endinterface

// File: rtl/div_ctrl_step.sv
// One combinational restoring-divide iteration.
// In: rem (WIDTH+1), quo (dividend bits shifting out), dvs. Out: rem', quo'.
module div_ctrl_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;

   assign sh     = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
   assign diff   = {1'b0, sh} - {2'b00, dvs_i};
   // a set top remainder bit means the shifted value exceeds any divisor
   assign borrow = diff[WIDTH+1] & ~rem_i[WIDTH];
   assign rem_o  = borrow ? sh : diff[WIDTH:0];
   assign quo_o  = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: stalls EX, runs WIDTH restoring steps,
// pulses result_valid_o with HI/LO. Ports: clk, rst, bus (div_ctrl_if.slave).
// Optional DIV_ZERO_FAST_EN: divisor 0 finishes in one cycle.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic       clk,
   input  logic       rst,
   div_ctrl_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   div_state_t       state, state_n;
   logic [WIDTH-1:0] a_r, b_r, quo, dvs, quo_n;
   logic [WIDTH-1:0] hi_r, lo_r, hi_fix, lo_fix;
   logic [WIDTH:0]   rem, rem_n;
   logic [CW-1:0]    cnt;
   logic             sgn_r, sign_q, sign_r;
   logic             go, zero_div, last, stall;

   assign go   = bus.start_i & ~bus.cancel_i;
   assign last = (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
   assign zero_div = (bus.opb_i == '0);
`else
   assign zero_div = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      stall   = 1'b0;
      unique case (state)
         DIV_IDLE: begin
            stall = go;
            if (go) state_n = zero_div ? DIV_DONE : DIV_PREP;
         end
         DIV_PREP: begin
            stall   = 1'b1;
            state_n = DIV_ITER;
         end
         DIV_ITER: begin
            stall = 1'b1;
            if (last) state_n = DIV_FIX;
         end
         DIV_FIX: begin
            stall   = 1'b1;
            state_n = DIV_DONE;
         end
         DIV_DONE: state_n = DIV_IDLE;
         default:  state_n = DIV_IDLE;
      endcase
      if (bus.cancel_i) state_n = DIV_IDLE;
   end

   div_ctrl_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem),
      .quo_i (quo),
      .dvs_i (dvs),
      .rem_o (rem_n),
      .quo_o (quo_n)
   );

   assign lo_fix = sign_q ? -quo : quo;
   assign hi_fix = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         sgn_r  <= 1'b0;
         quo    <= '0;
         dvs    <= '0;
         rem    <= '0;
         cnt    <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         case (state)
            DIV_IDLE: if (go) begin
               a_r   <= bus.opa_i;
               b_r   <= bus.opb_i;
               sgn_r <= bus.signed_i;
               if (zero_div) begin
                  hi_r <= bus.opa_i;
                  lo_r <= '1;
               end
            end
            DIV_PREP: begin
               quo    <= (sgn_r & a_r[WIDTH-1]) ? -a_r : a_r;
               dvs    <= (sgn_r & b_r[WIDTH-1]) ? -b_r : b_r;
               rem    <= '0;
               cnt    <= '0;
               sign_q <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               sign_r <= sgn_r & a_r[WIDTH-1];
            end
            DIV_ITER: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt + 1'b1;
            end
            DIV_FIX: if (!bus.cancel_i) begin
               hi_r <= hi_fix;
               lo_r <= lo_fix;
            end
            default: ;
         endcase
      end
   end

   assign bus.stall_o        = stall;
   assign bus.busy_o         = (state != DIV_IDLE);
   assign bus.result_valid_o = (state == DIV_DONE);
   assign bus.hi_o           = hi_r;
   assign bus.lo_o           = lo_r;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results,
// cancel, start held high, mid-run reset and divide by zero.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = DIV_LATENCY;
`endif

   div_ctrl_if #(.WIDTH(32)) bus ();

   div_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] elo,
                         input logic [31:0] ehi);
      int          vcyc = -1;
      int          npulse = 0;
      int          stall_bad = 0;
      logic [31:0] lo_c = '0;
      logic [31:0] hi_c = '0;
      tick();
      bus.start_i  = 1'b1;
      bus.signed_i = sgn;
      bus.opa_i    = a;
      bus.opb_i    = b;
      @(negedge clk);
      if (bus.stall_o !== 1'b1) stall_bad++;
      for (int k = 1; k <= 40; k++) begin
         tick();
         bus.start_i = 1'b0;
         @(negedge clk);
         if (bus.result_valid_o === 1'b1) begin
            npulse++;
            vcyc = k;
            lo_c = bus.lo_o;
            hi_c = bus.hi_o;
         end
         if (bus.stall_o !== (k < lat)) stall_bad++;
      end
      check({tag, " valid_cyc"}, vcyc, lat);
      check({tag, " pulses"}, npulse, 1);
      check({tag, " lo"}, lo_c, elo);
      check({tag, " hi"}, hi_c, ehi);
      check({tag, " stall"}, stall_bad, 0);
      check({tag, " lo_hold"}, bus.lo_o, elo);
      check({tag, " hi_hold"}, bus.hi_o, ehi);
   endtask

   initial begin
      int          npulse;
      int          vcyc;
      logic [31:0] lo_c;
      logic [31:0] hi_c;

      bus.start_i  = 1'b0;
      bus.signed_i = 1'b0;
      bus.opa_i    = '0;
      bus.opb_i    = '0;
      bus.cancel_i = 1'b0;

      tick();
      tick();
      @(negedge clk);
      check("rst busy", bus.busy_o, 0);
      check("rst valid", bus.result_valid_o, 0);
      check("rst stall", bus.stall_o, 0);
      check("rst hi", bus.hi_o, 0);
      check("rst lo", bus.lo_o, 0);
      rst = 1'b0;

      run_op("divu 7/2", 1'b0, 32'd7, 32'd2, DIV_LATENCY, 32'd3, 32'd1);
      run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, DIV_LATENCY,
             32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, DIV_LATENCY,
             32'hFFFF_FFFD, 32'd1);
      run_op("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, DIV_LATENCY,
             32'hFFFF_FFF2, 32'd2);
      run_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, DIV_LATENCY,
             32'hFFFF_FFFF, 32'd0);
      run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
             DIV_LATENCY, 32'h8000_0000, 32'd0);
      run_op("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
             DIV_LATENCY, 32'd0, 32'h8000_0000);

      // cancel in flight: 100/7 aborted at N+10
      tick();
      bus.start_i  = 1'b1;
      bus.signed_i = 1'b0;
      bus.opa_i    = 32'd100;
      bus.opb_i    = 32'd7;
      npulse = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         bus.start_i  = 1'b0;
         bus.cancel_i = (k == 10);
         @(negedge clk);
         if (bus.result_valid_o === 1'b1) npulse++;
         if (k == 10) check("cancel busy_before", bus.busy_o, 1);
         if (k == 11) check("cancel busy_after", bus.busy_o, 0);
      end
      check("cancel pulses", npulse, 0);
      check("cancel lo_keep", bus.lo_o, 32'd0);
      check("cancel hi_keep", bus.hi_o, 32'h8000_0000);

      // start and cancel together in IDLE
      tick();
      bus.start_i  = 1'b1;
      bus.cancel_i = 1'b1;
      @(negedge clk);
      check("start+cancel stall", bus.stall_o, 0);
      tick();
      bus.start_i  = 1'b0;
      bus.cancel_i = 1'b0;
      @(negedge clk);
      check("start+cancel busy", bus.busy_o, 0);

      // start held high through completion, then reset mid-run
      tick();
      bus.start_i  = 1'b1;
      bus.signed_i = 1'b0;
      bus.opa_i    = 32'd100;
      bus.opb_i    = 32'd7;
      npulse = 0;
      vcyc   = -1;
      lo_c   = '0;
      hi_c   = '0;
      for (int k = 1; k <= 36; k++) begin
         tick();
         @(negedge clk);
         if (bus.result_valid_o === 1'b1) begin
            npulse++;
            vcyc = k;
            lo_c = bus.lo_o;
            hi_c = bus.hi_o;
         end
      end
      check("held pulses", npulse, 1);
      check("held valid_cyc", vcyc, DIV_LATENCY);
      check("held lo", lo_c, 32'd14);
      check("held hi", hi_c, 32'd2);
      check("held rearm stall", bus.stall_o, 1);
      check("held rearm busy", bus.busy_o, 0);
      tick();
      bus.start_i = 1'b0;
      @(negedge clk);
      check("held rearm busy_next", bus.busy_o, 1);
      for (int k = 38; k < 56; k++) tick();
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("midrst busy", bus.busy_o, 0);
      check("midrst valid", bus.result_valid_o, 0);
      check("midrst stall", bus.stall_o, 0);
      check("midrst hi", bus.hi_o, 0);
      check("midrst lo", bus.lo_o, 0);
      rst = 1'b0;

      run_op("divu 5/0", 1'b0, 32'd5, 32'd0, ZLAT, 32'hFFFF_FFFF, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
